// File: rtl/regfile_bank_read_client_if.sv
// Bus bundle between an operand-collector requester, the bank read client,
// and the 1R1W register-file bank macro it drives.
//   slave  : the bank read client (accepts requests, drives the macro)
//   master : the requester side, which also hosts the macro pins
interface regfile_bank_read_client_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);

  // Tagged read request (valid/ready)
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [TAG_W-1:0]  rd_req_tag;

  // In-order tagged read response (valid/ready)
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [DATA_W-1:0] rd_rsp_data;
  logic [TAG_W-1:0]  rd_rsp_tag;

  // Fire-and-forget write strobe
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Macro write port
  logic              mem_W0_en;
  logic [ADDR_W-1:0] mem_W0_addr;
  logic [DATA_W-1:0] mem_W0_data;

  // Macro read port (data valid the cycle after mem_R0_en)
  logic              mem_R0_en;
  logic [ADDR_W-1:0] mem_R0_addr;
  logic [DATA_W-1:0] mem_R0_data;

  // Status
  logic              busy;

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_tag,
    output rd_req_ready,
    output rd_rsp_valid, rd_rsp_data, rd_rsp_tag,
    input  rd_rsp_ready,
    input  wr_valid, wr_addr, wr_data,
    output mem_W0_en, mem_W0_addr, mem_W0_data,
    output mem_R0_en, mem_R0_addr,
    input  mem_R0_data,
    output busy
  );

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_tag,
    input  rd_req_ready,
    input  rd_rsp_valid, rd_rsp_data, rd_rsp_tag,
    output rd_rsp_ready,
    output wr_valid, wr_addr, wr_data,
    input  mem_W0_en, mem_W0_addr, mem_W0_data,
    input  mem_R0_en, mem_R0_addr,
    output mem_R0_data,
    input  busy
  );

endinterface

// File: rtl/regfile_bank_read_client.sv
// Requester-side controller for one 1R1W register-file bank macro.
// Reads are issued the cycle they are accepted, the macro data is captured
// one cycle later (with a same-cycle write forwarded over it), and the
// result is parked in a 3-entry in-order response FIFO. Admission is
// limited so that every issued read always has a FIFO slot waiting for it.
// Writes pass straight through to the macro and are never stalled.
module regfile_bank_read_client #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input logic                        clock,
  input logic                        reset,   // asynchronous, active-low
  regfile_bank_read_client_if.slave  bus
);

  localparam int DEPTH = 3;

  typedef logic [1:0] ptr_t;

  // Advance a FIFO pointer, wrapping modulo DEPTH
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic              fire;
  logic              push;
  logic              pop;

  // Stage s1: the read issued last cycle, waiting for macro data
  logic              s1_valid;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_byp;
  logic [DATA_W-1:0] s1_bdata;

  // Response FIFO
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [TAG_W-1:0]  fifo_tag  [DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;

  logic [2:0]        occupancy;
  logic [DATA_W-1:0] capture_data;
  logic              same_addr_write;

  // ---------------------------------------------------------------------
  // Write path: straight pass-through, held off only while in reset
  // ---------------------------------------------------------------------
  assign bus.mem_W0_en   = bus.wr_valid & reset;
  assign bus.mem_W0_addr = bus.wr_addr;
  assign bus.mem_W0_data = bus.wr_data;

  // ---------------------------------------------------------------------
  // Admission and issue
  // ---------------------------------------------------------------------
  // Every accepted read owns a slot from acceptance until it is popped, so
  // counting s1 together with the FIFO makes overflow impossible. Ready
  // depends on registered state only (plus reset), never on rd_rsp_ready.
  assign occupancy        = {2'b00, s1_valid} + {1'b0, count};
  assign bus.rd_req_ready = reset & (occupancy < 3'(DEPTH));
  assign fire             = bus.rd_req_valid & bus.rd_req_ready;

  assign bus.mem_R0_en   = fire;
  assign bus.mem_R0_addr = bus.rd_req_addr;

  // A write in the issue cycle to the read address must win over whatever
  // the macro does on a same-cycle collision.
  assign same_addr_write = bus.wr_valid & (bus.wr_addr == bus.rd_req_addr);

  // s1 valid flag: tracks whether last cycle issued a read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else begin
      // NOTE: clocked state is always assigned with <= so every flop samples
      // pre-edge values regardless of block evaluation order.
      s1_valid <= fire;
    end
  end

  // s1 payload: tag and forwarded write data for the read in flight
  always_ff @(posedge clock) begin
    // NOTE: payload and FIFO storage carry no reset; they are only observed
    // when a reset-cleared valid flag or count says they hold live data.
    s1_tag   <= bus.rd_req_tag;
    s1_byp   <= fire & same_addr_write;
    s1_bdata <= bus.wr_data;
  end

  // ---------------------------------------------------------------------
  // Capture: macro data is only sampled in the cycle after issue
  // ---------------------------------------------------------------------
  // Select forwarded write data over the macro output for the s1 read
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    capture_data = bus.mem_R0_data;
    if (s1_byp) begin
      capture_data = s1_bdata;
    end
  end

  assign push = s1_valid;
  assign pop  = bus.rd_rsp_valid & bus.rd_rsp_ready;

  // ---------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------
  // Next occupancy of the FIFO: push and pop together leave it unchanged
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_next;
    end
  end

  // FIFO storage: write the captured response at the tail
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= capture_data;
      fifo_tag[wr_ptr]  <= s1_tag;
    end
  end

  // Head entry is presented directly; zeroed while the FIFO is empty so the
  // uninitialised storage never reaches the consumer.
  assign bus.rd_rsp_valid = (count != 2'd0);
  assign bus.rd_rsp_data  = bus.rd_rsp_valid ? fifo_data[rd_ptr] : '0;
  assign bus.rd_rsp_tag   = bus.rd_rsp_valid ? fifo_tag[rd_ptr]  : '0;

  assign bus.busy = s1_valid | (count != 2'd0);

  // A capture into a full FIFO with no pop would drop macro data; admission
  // control is meant to make that unreachable.
  fifo_no_overflow: assert property (
    @(posedge clock) disable iff (!reset)
      !(push && !pop && (count == 2'(DEPTH)))
  );

endmodule

// File: tb/tb_regfile_bank_read_client.sv
// Self-checking bench for regfile_bank_read_client. A behavioural bank macro
// sits on the memory pins; a reference array plus a queue of expected
// responses predicts every read, and a separate monitor pops and compares
// whenever the DUT hands over a response.
module tb_regfile_bank_read_client;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  regfile_bank_read_client_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  regfile_bank_read_client #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Bank macro: registered read returning pre-write contents on collision
  logic [DATA_W-1:0] macro_mem [2**ADDR_W];
  always @(posedge clock) begin
    if (bus.mem_W0_en) macro_mem[bus.mem_W0_addr] <= bus.mem_W0_data;
    if (bus.mem_R0_en) bus.mem_R0_data <= macro_mem[bus.mem_R0_addr];
  end

  // Reference model: architectural memory and expected responses
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    int                cyc;
  } exp_t;

  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  exp_t              exp_q [$];
  int                n_vec = 0;
  int                n_err = 0;
  int                cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the rising edge, then at the falling
  // edge check status against the model and update the model.
  task automatic step(input logic rst, input logic rv, input logic [ADDR_W-1:0] ra,
                      input logic [TAG_W-1:0] rt, input logic wv,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic rr, output logic fired);
    logic exp_ready;
    logic exp_valid;
    @(posedge clock);
    #1;
    reset            = rst;
    bus.rd_req_valid = rv;
    bus.rd_req_addr  = ra;
    bus.rd_req_tag   = rt;
    bus.wr_valid     = wv;
    bus.wr_addr      = wa;
    bus.wr_data      = wd;
    bus.rd_rsp_ready = rr;
    if (!rst) exp_q.delete();
    @(negedge clock);
    cyc++;
    exp_ready = rst && (exp_q.size() < DEPTH);
    exp_valid = (exp_q.size() != 0) && (exp_q[0].cyc <= cyc - 2);
    check("rd_req_ready", bus.rd_req_ready, exp_ready);
    check("busy", bus.busy, exp_q.size() != 0);
    check("rd_rsp_valid", bus.rd_rsp_valid, exp_valid);
    fired = rv && exp_ready;
    check("mem_R0_en", bus.mem_R0_en, fired);
    if (fired) check("mem_R0_addr", bus.mem_R0_addr, ra);
    check("mem_W0_en", bus.mem_W0_en, wv && rst);
    if (wv && rst) begin
      check("mem_W0_addr", bus.mem_W0_addr, wa);
      check("mem_W0_data", bus.mem_W0_data, wd);
      ref_mem[wa] = wd;
    end
    if (fired) exp_q.push_back('{data: ref_mem[ra], tag: rt, cyc: cyc});
  endtask

  task automatic idle(input logic rr);
    logic f;
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, rr, f);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: consume responses as the DUT hands them over
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (reset && bus.rd_rsp_valid && bus.rd_rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", bus.rd_rsp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", bus.rd_rsp_data, e.data);
          check("rsp_tag", bus.rd_rsp_tag, e.tag);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    int   k;
    int   accepted;
    int   guard;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      macro_mem[i] = '0;
      ref_mem[i]   = '0;
    end
    bus.mem_R0_data  = '0;
    bus.rd_req_valid = 1'b0;
    bus.rd_req_addr  = '0;
    bus.rd_req_tag   = '0;
    bus.wr_valid     = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.rd_rsp_ready = 1'b0;

    // Reset: requests and writes presented but nothing may reach the macro
    step(1'b0, 1'b1, 8'h05, 4'h1, 1'b1, 8'h05, 32'h1, 1'b1, f);
    step(1'b0, 1'b1, 8'h05, 4'h1, 1'b1, 8'h05, 32'h1, 1'b1, f);
    check("reset_rsp_data", bus.rd_rsp_data, 0);
    check("reset_rsp_tag", bus.rd_rsp_tag, 0);

    // Write then read back with two-cycle latency
    step(1'b1, 1'b0, '0, '0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b1, f);
    step(1'b1, 1'b1, 8'h10, 4'd3, 1'b0, '0, '0, 1'b1, f);
    idle(1'b1);
    idle(1'b1);
    check("t1_valid", bus.rd_rsp_valid, 1'b1);
    check("t1_data", bus.rd_rsp_data, 32'hDEADBEEF);
    check("t1_tag", bus.rd_rsp_tag, 4'd3);
    drain();

    // Same-cycle write forward; a later write must not leak into the result
    step(1'b1, 1'b1, 8'h22, 4'd5, 1'b1, 8'h22, 32'h12345678, 1'b0, f);
    step(1'b1, 1'b0, '0, '0, 1'b1, 8'h22, 32'hFFFFFFFF, 1'b0, f);
    idle(1'b0);
    check("t2_data", bus.rd_rsp_data, 32'h12345678);
    check("t2_tag", bus.rd_rsp_tag, 4'd5);
    drain();

    // Backpressure: three accepted, the fourth waits until a pop
    for (int a = 1; a <= 3; a++)
      step(1'b1, 1'b1, ADDR_W'(a), TAG_W'(a), 1'b0, '0, '0, 1'b0, f);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 8'd4, 4'd4, 1'b0, '0, '0, 1'b0, f);
    check("t3_full_busy", bus.busy, 1'b1);
    k = 0;
    f = 1'b0;
    while (!f && k < 10) begin
      step(1'b1, 1'b1, 8'd4, 4'd4, 1'b0, '0, '0, 1'b1, f);
      k++;
    end
    check("t3_addr4_accept_delay", k, 2);
    drain();

    // Preload and stream 16 back-to-back reads
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, '0, '0, 1'b1, ADDR_W'(i), DATA_W'(i * 3), 1'b1, f);
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, ADDR_W'(i), TAG_W'(i), 1'b0, '0, '0, 1'b1, f);
    drain();

    // Random traffic with 50% response backpressure
    accepted = 0;
    guard    = 0;
    while (accepted < 1000 && guard < 20000) begin
      step(1'b1, ($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 31)),
           TAG_W'(accepted), ($urandom_range(0, 1) == 1), ADDR_W'($urandom_range(0, 31)),
           DATA_W'($urandom), ($urandom_range(0, 1) == 1), f);
      if (f) accepted++;
      guard++;
    end
    drain();

    // Reset with one read in s1 and two buffered
    step(1'b1, 1'b0, '0, '0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, f);
    for (int a = 0; a < 3; a++)
      step(1'b1, 1'b1, ADDR_W'(a + 8), TAG_W'(a), 1'b0, '0, '0, 1'b0, f);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, f);
    check("t6_reset_valid", bus.rd_rsp_valid, 1'b0);
    check("t6_reset_busy", bus.busy, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, f);
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(1'b1, 1'b1, 8'h10, 4'd7, 1'b0, '0, '0, 1'b1, f);
    idle(1'b1);
    idle(1'b1);
    check("t6_valid", bus.rd_rsp_valid, 1'b1);
    check("t6_data", bus.rd_rsp_data, 32'hDEADBEEF);
    check("t6_tag", bus.rd_rsp_tag, 4'd7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
